// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main sequencing controller for the multi-cycle ARM-subset core.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// decodes datapath selects and enables from the state register, latches the
// immediate-extension controls at decode and watches memory wait states.
module mc_ctrl_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       CondEx,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic [1:0] ResultSrc,
    output logic       PCWrite,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] ImmSrc,
    output logic       IsMovt,
    output logic       IsMovm,
    output logic       MemErr
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        MOVX
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             in_wait;
    logic             timeout;
    logic [1:0]       imm_src_next;
    logic             is_movt_next;
    logic             is_movm_next;

    // State, wait counter, latched extension controls and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            ImmSrc   <= 2'b00;
            IsMovt   <= 1'b0;
            IsMovm   <= 1'b0;
            MemErr   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ImmSrc   <= imm_src_next;
            IsMovt   <= is_movt_next;
            IsMovm   <= is_movm_next;
            if (timeout) begin
                MemErr <= 1'b1;
            end
        end
    end

    // Next state plus Moore-decoded selects/enables; writes are forced off while reset is low.
    always_comb begin
        state_next = state;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 1'b0;
        ResultSrc  = 2'b00;
        PCWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        in_wait    = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
        timeout    = in_wait && !MemReady && (wait_cnt == WAIT_LIMIT);

        case (state)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = MOVX;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegW       = CondEx;
                state_next = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = CondEx & MemReady;
                if (MemReady) begin
                    state_next = FETCH;
                end
            end
            EXECR: begin
                ALUOp      = 1'b1;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUOp      = 1'b1;
                state_next = ALUWB;
            end
            MOVX: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegW       = CondEx;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = CondEx;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (timeout) begin
            state_next = FETCH;
        end

        if (!reset) begin
            IRWrite = 1'b0;
            PCWrite = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
        end
    end

    // Wait counter restarts on every state entry and saturates while memory stalls.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if ((state_next != state) || timeout) begin
            wait_cnt_next = '0;
        end else if (in_wait && !MemReady && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // Extension controls change only in DECODE; every other cycle they hold.
    always_comb begin
        imm_src_next = ImmSrc;
        is_movt_next = IsMovt;
        is_movm_next = IsMovm;
        if (state == DECODE) begin
            case (Op)
                2'b00: begin
                    if (Funct[5]) begin
                        if (Funct[4:1] == 4'b1101) begin
                            imm_src_next = 2'b11;
                            is_movt_next = 1'b0;
                            is_movm_next = 1'b0;
                        end else begin
                            imm_src_next = 2'b00;
                        end
                    end
                end
                2'b01: imm_src_next = 2'b01;
                2'b10: imm_src_next = 2'b10;
                default: begin
                    imm_src_next = 2'b11;
                    is_movt_next = ~Funct[0];
                    is_movm_next = Funct[0];
                end
            endcase
        end
    end

endmodule
